wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 Parameter BASE_ADR, 32'h0000_0000, byte base address of the 16 KiB RAM window; bits [13:0] SHALL be zero.
REQ-002 clk_i  in  1  single clock; all state on rising edge.
REQ-003 rst_i  in  1  reset, synchronous, active-high.
REQ-004 wb_cyc_i, wb_stb_i, wb_we_i  in  1 each  Wishbone B3 cycle, strobe, write-enable.
REQ-005 wb_adr_i  in  32  byte address; [1:0] ignored.
REQ-006 wb_sel_i  in  4  byte selects; wb_dat_i  in  32  write data.
REQ-007 wb_cti_i  in  3  cycle type (000 classic, 010 incrementing, 111 end-of-burst); wb_bte_i  in  2  burst type (00 linear, 01 wrap4, 10 wrap8, 11 wrap16).
REQ-008 wb_dat_o  out  32  read data; wb_ack_o  out  1  acknowledge; wb_err_o  out  1  error.
REQ-009 ram_we_o  out  1, ram_adr_o  out  12 (word address), ram_be_o  out  4, ram_dat_o  out  32  to single-port RAM.
REQ-010 ram_dat_i  in  32  RAM read data, valid one clock after ram_adr_o is sampled.

Function
REQ-011 hit SHALL be wb_adr_i[31:14] == BASE_ADR[31:14]; req SHALL be wb_cyc_i & wb_stb_i.
REQ-012 States SHALL be IDLE, ACK, ERR, BURST.
REQ-013 ram_be_o SHALL equal wb_sel_i, ram_dat_o SHALL equal wb_dat_i, wb_dat_o SHALL equal ram_dat_i (combinational pass-through).
REQ-014 IDLE: ram_adr_o = wb_adr_i[13:2]; ram_we_o = req & wb_we_i & hit, asserted only in IDLE.
REQ-015 IDLE transitions: req & !hit -> ERR; req & hit & (wb_we_i | wb_cti_i != 010) -> ACK; req & hit & !wb_we_i & wb_cti_i == 010 -> BURST; else stay.
REQ-016 ACK: wb_ack_o = req for exactly one cycle, then IDLE; single read/write latency SHALL be one cycle after strobe sampled in IDLE.
REQ-017 ERR: wb_err_o = req for one cycle, then IDLE; no RAM write SHALL occur for a miss.
REQ-018 Writes SHALL always be single-beat; wb_cti_i SHALL be ignored when wb_we_i = 1.
REQ-019 BURST: wb_ack_o = req & !wb_we_i; when acked, ram_adr_o = next(wb_adr_i[13:2]) so consecutive beats ack every cycle; when not acked, ram_adr_o = wb_adr_i[13:2].
REQ-020 next(): bte 00 word+1 modulo 4096; 01/10/11 increment low 2/3/4 bits only, upper bits held.
REQ-021 BURST exits to IDLE on: ack with wb_cti_i == 111; !req (master wait, burst restarts from IDLE); wb_we_i = 1 (no ack); !hit (no ack).
REQ-022 wb_ack_o and wb_err_o SHALL never be asserted together nor while !wb_cyc_i.
REQ-023 wb_cyc_i deasserted in any state SHALL return the FSM to IDLE next cycle.

Reset
REQ-024 rst_i high SHALL force IDLE at next edge; while rst_i high, wb_ack_o, wb_err_o, ram_we_o SHALL be 0.
REQ-025 Reset mid-burst or mid-ACK SHALL abandon the transfer with no further ack.

Structure
REQ-026 Package wb_pkg SHALL hold cti/bte enums and the state enum.
REQ-027 next() SHALL be a combinational sub-module wb_burst_adr_next (12-bit adr, bte in; adr out).
REQ-028 No storage of RAM data in this block; RAM instantiated by parent.

Verification
REQ-029 Write 0xDEADBEEF to 0x0000_0010, sel 1111 -> ram_we_o=1 with ram_adr_o=4 same cycle, ack next cycle; readback ack one cycle later with wb_dat_o=0xDEADBEEF.
REQ-030 Write 0x0000AB00 to 0x10, sel 0010 -> ram_be_o=0010; readback 0xDEADABEF.
REQ-031 Wrap4 read burst from 0x0C, cti 010,010,010,111 -> word addresses 3,0,1,2, four acks on consecutive cycles starting one cycle after first strobe, then IDLE.
REQ-032 Linear burst at 0x3FFC -> next ram_adr_o = 0.
REQ-033 Access 0x0001_0000 with BASE_ADR 0 -> wb_err_o one cycle later, ram_we_o never 1, no ack.
REQ-034 rst_i pulsed during second beat of burst -> wb_ack_o 0 from that cycle; next strobe restarts from IDLE with one-cycle latency.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types for the Wishbone RAM slave: cycle/burst type encodings and FSM states.
// Pure declarations, no logic.
package wb_pkg;

    localparam int RAM_AW = 12;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_EOB     = 3'b111
    } cti_e;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACK   = 2'b01,
        ST_ERR   = 2'b10,
        ST_BURST = 2'b11
    } state_e;

endpackage

// File: rtl/wb_ram_slave_if.sv
// Wishbone B3 slave-side bus bundle; signal names are from the slave's point of view.
// Master modport drives requests, slave modport drives responses.
interface wb_ram_slave_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_dat_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i, wb_cti_i, wb_bte_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );
endinterface

// File: rtl/wb_burst_adr_next.sv
// Next word address of an incrementing burst: linear wraps at 4096 words, wrapN only moves the low bits.
// Purely combinational, no handshake.
module wb_burst_adr_next
    import wb_pkg::*;
(
    input  logic [RAM_AW-1:0] adr_i,
    input  bte_e              bte_i,
    output logic [RAM_AW-1:0] adr_o
);
    always_comb begin
        adr_o = adr_i + 12'd1;
        case (bte_i)
            BTE_WRAP4:  adr_o = {adr_i[11:2], adr_i[1:0] + 2'd1};
            BTE_WRAP8:  adr_o = {adr_i[11:3], adr_i[2:0] + 3'd1};
            BTE_WRAP16: adr_o = {adr_i[11:4], adr_i[3:0] + 4'd1};
            default:    adr_o = adr_i + 12'd1;
        endcase
    end
endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone B3 slave in front of a 16 KiB single-port synchronous RAM owned by the parent.
// Singles ack one cycle after the strobe; incrementing read bursts ack every cycle; misses get err.
module wb_ram_slave
    import wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_ram_slave_if.slave     wb,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_adr_o,
    output logic [3:0]        ram_be_o,
    output logic [31:0]       ram_dat_o,
    input  logic [31:0]       ram_dat_i
);
    state_e            state_q;
    state_e            state_d;
    logic              req;
    logic              hit;
    logic              burst_ack;
    logic [RAM_AW-1:0] word_adr;
    logic [RAM_AW-1:0] word_adr_nxt;
    logic              ack;
    logic              err;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_adr;
    logic              unused_adr_lsb;

    assign req            = wb.wb_cyc_i & wb.wb_stb_i;
    assign hit            = (wb.wb_adr_i[31:14] == BASE_ADR[31:14]);
    assign word_adr       = wb.wb_adr_i[13:2];
    assign burst_ack      = req & ~wb.wb_we_i & hit;
    assign unused_adr_lsb = ^wb.wb_adr_i[1:0];

    wb_burst_adr_next u_adr_next (
        .adr_i (word_adr),
        .bte_i (bte_e'(wb.wb_bte_i)),
        .adr_o (word_adr_nxt)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (!hit) begin
                        state_d = ST_ERR;
                    end else if (wb.wb_we_i || (wb.wb_cti_i != CTI_INCR)) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_BURST;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            ST_BURST: begin
                // Any master wait, write or miss drops back; the next strobe restarts from IDLE.
                if (!burst_ack || (wb.wb_cti_i == CTI_EOB)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ack     = 1'b0;
        err     = 1'b0;
        ram_we  = 1'b0;
        ram_adr = word_adr;
        case (state_q)
            ST_IDLE:  ram_we = req & wb.wb_we_i & hit;
            ST_ACK:   ack    = req;
            ST_ERR:   err    = req;
            ST_BURST: begin
                ack = burst_ack;
                // Prefetch the following beat so the RAM output lines up with the next ack.
                if (burst_ack) begin
                    ram_adr = word_adr_nxt;
                end
            end
            default: ;
        endcase
        if (rst_i) begin
            ack    = 1'b0;
            err    = 1'b0;
            ram_we = 1'b0;
        end
    end

    assign wb.wb_ack_o = ack;
    assign wb.wb_err_o = err;
    assign wb.wb_dat_o = ram_dat_i;
    assign ram_we_o    = ram_we;
    assign ram_adr_o   = ram_adr;
    assign ram_be_o    = wb.wb_sel_i;
    assign ram_dat_o   = wb.wb_dat_i;
endmodule

// File: tb/tb_wb_ram_slave.sv
// Randomized bench for wb_ram_slave with a behavioural memory model and response scoreboard.
module tb_wb_ram_slave;
    localparam logic [31:0] BASE = 32'h0000_0000;

    typedef struct {
        bit          is_err;
        bit          chk_dat;
        logic [31:0] dat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_clr = 1'b1;
    logic        ram_we_o;
    logic [11:0] ram_adr_o;
    logic [3:0]  ram_be_o;
    logic [31:0] ram_dat_o;
    logic [31:0] ram_dat_i;

    logic [31:0] mem [4096];
    bit   [31:0] ref_mem [4096];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;

    wb_ram_slave_if wb ();

    wb_ram_slave #(.BASE_ADR(BASE)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .wb        (wb),
        .ram_we_o  (ram_we_o),
        .ram_adr_o (ram_adr_o),
        .ram_be_o  (ram_be_o),
        .ram_dat_o (ram_dat_o),
        .ram_dat_i (ram_dat_i)
    );

    always #5 clk = ~clk;

    // Parent-side synchronous RAM: byte-enable write, one-cycle registered read.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 4096; i++) mem[i] <= '0;
        end else if (ram_we_o) begin
            for (int b = 0; b < 4; b++)
                if (ram_be_o[b]) mem[ram_adr_o][8*b +: 8] <= ram_dat_o[8*b +: 8];
        end
        ram_dat_i <= mem[ram_adr_o];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
        end
    endtask

    function automatic logic [11:0] nxt(input logic [11:0] w, input logic [1:0] bte);
        int wi;
        int n;
        wi = int'(w);
        if (bte == 2'b00) return 12'((wi + 1) % 4096);
        n = 2 << bte;
        return 12'((wi / n) * n + ((wi % n) + 1) % n);
    endfunction

    function automatic logic [11:0] rnd_word();
        if ($urandom_range(0, 3) == 0) return 12'hFF0 + 12'($urandom_range(0, 15));
        return 12'($urandom_range(0, 31));
    endfunction

    function automatic logic [31:0] hit_adr(input logic [11:0] w);
        return {BASE[31:14], w, 2'($urandom)};
    endfunction

    task automatic set_bus(input bit cyc, input logic [31:0] adr, input bit we, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [2:0] cti, input logic [1:0] bte);
        wb.wb_cyc_i = cyc;
        wb.wb_stb_i = cyc;
        wb.wb_we_i  = we;
        wb.wb_adr_i = adr;
        wb.wb_sel_i = sel;
        wb.wb_dat_i = dat;
        wb.wb_cti_i = cti;
        wb.wb_bte_i = bte;
    endtask

    task automatic release_bus();
        @(posedge clk); #1;
        set_bus(0, 32'h0, 0, 4'h0, 32'h0, 3'b000, 2'b00);
    endtask

    task automatic wait_resp(input int start, output int waits, output logic [31:0] rdat,
                             output logic [11:0] radr);
        waits = start;
        rdat  = '0;
        radr  = '0;
        forever begin
            @(negedge clk);
            if (wb.wb_ack_o || wb.wb_err_o) begin
                rdat = wb.wb_dat_o;
                radr = ram_adr_o;
                break;
            end
            waits++;
            if (waits > 16) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_timeout: no ack/err after %0d cycles at %0t", waits, $time);
                break;
            end
        end
    endtask

    task automatic single(input logic [31:0] adr, input bit we, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [2:0] cti, output logic [31:0] rdat);
        bit          hit;
        logic [11:0] w;
        exp_t        e;
        int          waits;
        logic [11:0] ra;
        hit       = (adr[31:14] == BASE[31:14]);
        w         = adr[13:2];
        e.is_err  = !hit;
        e.chk_dat = hit && !we;
        e.dat     = ref_mem[w];
        if (hit && we)
            for (int b = 0; b < 4; b++)
                if (sel[b]) ref_mem[w][8*b +: 8] = dat[8*b +: 8];
        exp_q.push_back(e);
        @(posedge clk); #1;
        set_bus(1, adr, we, sel, dat, cti, 2'($urandom));
        @(negedge clk);
        chk("no_early_resp", {31'b0, wb.wb_ack_o | wb.wb_err_o}, 32'd0);
        chk("idle_ram_we", {31'b0, ram_we_o}, {31'b0, hit && we});
        chk("idle_ram_adr", {20'b0, ram_adr_o}, {20'b0, w});
        if (hit && we) begin
            chk("wr_be", {28'b0, ram_be_o}, {28'b0, sel});
            chk("wr_dat", ram_dat_o, dat);
        end
        wait_resp(1, waits, rdat, ra);
        chk("single_latency", waits, 1);
        release_bus();
    endtask

    task automatic burst(input logic [11:0] w0, input logic [1:0] bte, input int len, input bit gaps);
        logic [11:0] w;
        bit          first;
        int          waits;
        logic [31:0] rd;
        logic [11:0] ra;
        exp_t        e;
        w     = w0;
        first = 1;
        for (int k = 0; k < len; k++) begin
            if (gaps && k > 0 && $urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                wb.wb_stb_i = 1'b0;
                if ($urandom_range(0, 1) == 1) wb.wb_cyc_i = 1'b0;
                first = 1;
            end
            e.is_err  = 0;
            e.chk_dat = 1;
            e.dat     = ref_mem[w];
            exp_q.push_back(e);
            @(posedge clk); #1;
            set_bus(1, hit_adr(w), 0, 4'hF, 32'h0, (k == len - 1) ? 3'b111 : 3'b010, bte);
            wait_resp(0, waits, rd, ra);
            chk("burst_latency", waits, first ? 1 : 0);
            if (!(first && k == len - 1))
                chk("burst_next_adr", {20'b0, ra}, {20'b0, nxt(w, bte)});
            first = 0;
            w     = nxt(w, bte);
        end
        release_bus();
    endtask

    task automatic reset_mid_burst();
        logic [11:0] w;
        exp_t        e;
        int          waits;
        logic [31:0] rd;
        logic [11:0] ra;
        w         = 12'd8;
        e.is_err  = 0;
        e.chk_dat = 1;
        e.dat     = ref_mem[w];
        exp_q.push_back(e);
        @(posedge clk); #1;
        set_bus(1, hit_adr(w), 0, 4'hF, 32'h0, 3'b010, 2'b00);
        wait_resp(0, waits, rd, ra);
        chk("rst_beat0_latency", waits, 1);
        @(posedge clk); #1;
        set_bus(1, hit_adr(w + 12'd1), 0, 4'hF, 32'h0, 3'b010, 2'b00);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_beat1_ack", {31'b0, wb.wb_ack_o}, 32'd0);
        chk("rst_beat1_err", {31'b0, wb.wb_err_o}, 32'd0);
        @(posedge clk); #1;
        rst       = 1'b0;
        e.dat     = ref_mem[w + 12'd2];
        exp_q.push_back(e);
        set_bus(1, hit_adr(w + 12'd2), 0, 4'hF, 32'h0, 3'b000, 2'b00);
        @(negedge clk);
        chk("post_rst_no_early", {31'b0, wb.wb_ack_o}, 32'd0);
        wait_resp(1, waits, rd, ra);
        chk("post_rst_latency", waits, 1);
        release_bus();
    endtask

    // Scoreboard monitor: every response the DUT presents consumes one expected entry.
    always @(negedge clk) begin
        if (wb.wb_ack_o || wb.wb_err_o) begin
            chk("ack_err_excl", {31'b0, wb.wb_ack_o & wb.wb_err_o}, 32'd0);
            chk("resp_needs_cyc", {31'b0, wb.wb_cyc_i}, 32'd1);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_resp: ack=%0b err=%0b with nothing outstanding at %0t",
                         wb.wb_ack_o, wb.wb_err_o, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("resp_is_err", {31'b0, wb.wb_err_o}, {31'b0, mon_e.is_err});
                if (mon_e.chk_dat && wb.wb_ack_o) chk("rdata", wb.wb_dat_o, mon_e.dat);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int          t;
        logic [11:0] w;
        set_bus(0, 32'h0, 0, 4'h0, 32'h0, 3'b000, 2'b00);
        repeat (2) @(posedge clk);
        #1 mem_clr = 1'b0;
        @(negedge clk);
        chk("reset_ack", {31'b0, wb.wb_ack_o}, 32'd0);
        chk("reset_err", {31'b0, wb.wb_err_o}, 32'd0);
        set_bus(1, hit_adr(12'd5), 1, 4'hF, 32'h1234_5678, 3'b000, 2'b00);
        repeat (2) begin
            @(negedge clk);
            chk("reset_ram_we", {31'b0, ram_we_o}, 32'd0);
            chk("reset_ack_req", {31'b0, wb.wb_ack_o}, 32'd0);
        end
        @(posedge clk); #1;
        set_bus(0, 32'h0, 0, 4'h0, 32'h0, 3'b000, 2'b00);
        @(posedge clk); #1 rst = 1'b0;

        single(32'h0000_0010, 1, 4'b1111, 32'hDEAD_BEEF, 3'b000, rd);
        single(32'h0000_0010, 0, 4'b1111, 32'h0, 3'b000, rd);
        chk("dir_readback_deadbeef", rd, 32'hDEAD_BEEF);
        single(32'h0000_0010, 1, 4'b0010, 32'h0000_AB00, 3'b010, rd);
        single(32'h0000_0010, 0, 4'b1111, 32'h0, 3'b000, rd);
        chk("dir_readback_merged", rd, 32'hDEAD_ABEF);

        for (int i = 0; i < 4; i++) single(hit_adr(12'(i)), 1, 4'hF, $urandom, 3'b000, rd);
        burst(12'd3, 2'b01, 4, 0);
        burst(12'hFFF, 2'b00, 2, 0);
        single(32'h0001_0000, 1, 4'hF, 32'hCAFE_F00D, 3'b000, rd);
        single(32'h0001_0000, 0, 4'hF, 32'h0, 3'b010, rd);
        reset_mid_burst();

        for (int i = 0; i < 200; i++) begin
            t = $urandom_range(0, 9);
            w = rnd_word();
            if (t <= 3) begin
                single(hit_adr(w), 1, 4'($urandom), $urandom, 3'($urandom), rd);
            end else if (t <= 5) begin
                single(hit_adr(w), 0, 4'hF, 32'h0, ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000, rd);
            end else if (t == 6) begin
                single({BASE[31:14] ^ 18'($urandom_range(1, 262143)), 14'($urandom)},
                       1'($urandom), 4'hF, $urandom, 3'b010, rd);
            end else begin
                burst(w, 2'($urandom), $urandom_range(2, 6), 1);
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        repeat (3) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
